aes_mmio_responder: RTL and testbench

- Memory-mapped responder on the processor's execute-stage store/load bus: consumes MemWriteX/ALUResultX/RD2X and returns aes_read.
- Collects a 128-bit key and plaintext, launches the AES core, captures the ciphertext and presents status and result words for processor loads.
- Sits between the 6-stage core and the AES datapath at the top level.

---
 rtl/aes_mmio_responder.sv | 201 ++++++++++++++++++++
 tb/tb_aes_mmio_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mmio_responder.sv
// -----------------------------------------------------------------------------
// aes_mmio_responder
//
// Memory-mapped front end for an AES core, attached to the processor's
// execute-stage store bus. Stores to the data window fill an 8-word buffer.
// Words 0..3 form the key and words 4..7 form the plaintext. A store to the
// command register launches the core, clears the block, or selects which view
// is returned on aes_read. The ciphertext is captured when the core completes.
//
// Optional feature macro: AES_MMIO_TIMEOUT_EN
//   When defined, a BUSY watchdog forces DONE after TIMEOUT_CYCLES cycles
//   without aes_done and sets the timeout and err flags.
//   When undefined, no watchdog is built and status bit3 reads 0.
//
// Ports:
//   clk            in   1    clock
//   reset          in   1    asynchronous active-low reset
//   MemWriteX      in   1    store strobe (execute stage)
//   ALUResultX     in   32   byte address (execute stage)
//   RD2X           in   32   store data
//   aes_read       out  32   registered read view selected by RSEL
//   aes_key        out  128  key to AES core (buffer words 0..3)
//   aes_plaintext  out  128  plaintext to AES core (buffer words 4..7)
//   aes_start      out  1    one-cycle launch pulse
//   aes_done       in   1    core completion pulse
//   aes_ciphertext in   128  core result, valid with aes_done
// -----------------------------------------------------------------------------
module aes_mmio_responder #(
  parameter logic [31:0] CMD_ADDR       = 32'd77,
  parameter logic [29:0] WIN_WORD       = 30'd14,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         MemWriteX,
  input  logic [31:0]  ALUResultX,
  input  logic [31:0]  RD2X,
  output logic [31:0]  aes_read,
  output logic [127:0] aes_key,
  output logic [127:0] aes_plaintext,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_ciphertext
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t         r_state;
  logic [3:0]     r_wptr;
  logic [2:0]     r_rsel;
  logic           r_done;
  logic           r_err;
  logic [31:0]    r_buf [8];
  logic [127:0]   r_result;
  logic [31:0]    r_read;
  logic           r_start;

  logic           w_cmd_wr;
  logic           w_dat_wr;
  logic           w_clear;
  logic           w_start_cmd;
  logic           w_busy_entry;
  logic           w_dat_accept;
  logic           w_tmo_hit;
  logic           w_timeout_flag;
  logic [31:0]    w_status;

  assign w_cmd_wr     = MemWriteX && (ALUResultX == CMD_ADDR);
  // The byte offset inside the window word is deliberately ignored.
  assign w_dat_wr     = MemWriteX && (ALUResultX[31:2] == WIN_WORD);
  assign w_clear      = w_cmd_wr && RD2X[1];
  assign w_start_cmd  = w_cmd_wr && RD2X[0];
  // CLEAR outranks START when both bits are set in one command.
  assign w_busy_entry = w_start_cmd && !w_clear && (r_wptr == 4'd8) &&
                        ((r_state == ST_LOAD) || (r_state == ST_DONE));
  assign w_dat_accept = w_dat_wr && (r_state != ST_BUSY) && (r_wptr != 4'd8);

  assign w_status = {21'd0, r_rsel, r_wptr, w_timeout_flag, r_err, r_done,
                     (r_state == ST_BUSY)};

  assign aes_key       = {r_buf[0], r_buf[1], r_buf[2], r_buf[3]};
  assign aes_plaintext = {r_buf[4], r_buf[5], r_buf[6], r_buf[7]};
  assign aes_start     = r_start;
  assign aes_read      = r_read;

`ifdef AES_MMIO_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 32'd1);

  logic [31:0] r_tcnt;
  logic        r_timeout;

  // The limit is reached on the TIMEOUT_CYCLES-th BUSY cycle. A coincident
  // aes_done or CLEAR takes precedence over the watchdog.
  assign w_tmo_hit = (r_state == ST_BUSY) && (r_tcnt == TMO_LAST) &&
                     !aes_done && !w_clear;
  assign w_timeout_flag = r_timeout;

  // BUSY watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcnt    <= 32'd0;
      r_timeout <= 1'b0;
    end else if (w_clear) begin
      r_tcnt    <= 32'd0;
      r_timeout <= 1'b0;
    end else begin
      if (w_busy_entry) begin
        r_tcnt <= 32'd0;
      end else if (r_state == ST_BUSY) begin
        r_tcnt <= r_tcnt + 32'd1;
      end
      if (w_tmo_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_tmo_hit      = 1'b0;
  assign w_timeout_flag = 1'b0;
`endif

  // Control FSM, load buffer, flags and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_wptr   <= 4'd0;
      r_rsel   <= 3'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= 128'd0;
      r_start  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_buf[i] <= 32'd0;
      end
    end else begin
      r_start <= 1'b0;
      if (w_cmd_wr) begin
        r_rsel <= RD2X[4:2];
      end
      if (w_clear) begin
        // Buffer contents and the last result are intentionally retained.
        r_state <= ST_IDLE;
        r_wptr  <= 4'd0;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        if (w_busy_entry) begin
          r_state <= ST_BUSY;
          r_start <= 1'b1;
        end else if (w_start_cmd) begin
          r_err <= 1'b1;
        end
        if (w_dat_wr) begin
          if (w_dat_accept) begin
            r_buf[r_wptr[2:0]] <= RD2X;
            r_wptr             <= r_wptr + 4'd1;
            if (r_state == ST_IDLE) begin
              r_state <= ST_LOAD;
            end
          end else begin
            r_err <= 1'b1;
          end
        end
        // Completion is only honoured in BUSY; stray pulses elsewhere are ignored.
        if (r_state == ST_BUSY) begin
          if (aes_done) begin
            r_state  <= ST_DONE;
            r_result <= aes_ciphertext;
            r_done   <= 1'b1;
          end else if (w_tmo_hit) begin
            r_state <= ST_DONE;
            r_err   <= 1'b1;
          end
        end
      end
    end
  end

  // Read view register: refreshed every cycle from RSEL, no side effects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read <= 32'd0;
    end else begin
      case (r_rsel)
        3'd0:    r_read <= w_status;
        3'd1:    r_read <= r_result[127:96];
        3'd2:    r_read <= r_result[95:64];
        3'd3:    r_read <= r_result[63:32];
        3'd4:    r_read <= r_result[31:0];
        3'd5:    r_read <= {28'd0, r_wptr};
        default: r_read <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mmio_responder.sv
// -----------------------------------------------------------------------------
// tb_aes_mmio_responder
//
// Self-checking bench for aes_mmio_responder. Operand sets expected at launch
// are queued when the buffer is filled, and ciphertexts expected on readback
// are queued when the model core returns them. Both are compared when the DUT
// presents them. The watchdog scenario adapts to AES_MMIO_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_aes_mmio_responder;

`ifdef AES_MMIO_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 1024;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         MemWriteX = 1'b0;
  logic [31:0]  ALUResultX = 32'd0;
  logic [31:0]  RD2X = 32'd0;
  logic [31:0]  aes_read;
  logic [127:0] aes_key;
  logic [127:0] aes_plaintext;
  logic         aes_start;
  logic         aes_done = 1'b0;
  logic [127:0] aes_ciphertext = 128'd0;

  int n_pass  = 0;
  int n_total = 0;

  logic [255:0] op_q [$];
  logic [127:0] ct_q [$];
  logic [127:0] model_result = 128'd0;

  aes_mmio_responder #(.TIMEOUT_CYCLES(TMO)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .MemWriteX      (MemWriteX),
    .ALUResultX     (ALUResultX),
    .RD2X           (RD2X),
    .aes_read       (aes_read),
    .aes_key        (aes_key),
    .aes_plaintext  (aes_plaintext),
    .aes_start      (aes_start),
    .aes_done       (aes_done),
    .aes_ciphertext (aes_ciphertext)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_store(input logic [31:0] addr, input logic [31:0] data);
    MemWriteX  = 1'b1;
    ALUResultX = addr;
    RD2X       = data;
    tick();
    MemWriteX  = 1'b0;
    ALUResultX = 32'd0;
    RD2X       = 32'd0;
  endtask

  task automatic read_view(input logic [2:0] sel, output logic [31:0] v);
    bus_store(32'd77, {27'd0, sel, 2'b00});
    tick();
    v = aes_read;
  endtask

  // Fill all 8 words and queue the operands expected at launch.
  task automatic load8(input logic [31:0] base, output logic [255:0] ops);
    logic [31:0] w;
    ops = 256'd0;
    for (int i = 0; i < 8; i++) begin
      w = base + 32'(i) * 32'h04040404;
      ops[255 - 32*i -: 32] = w;
      bus_store(32'd56 + 32'(i % 4), w);
    end
    op_q.push_back(ops);
  endtask

  task automatic pulse_done(input logic [127:0] ct);
    aes_done       = 1'b1;
    aes_ciphertext = ct;
    tick();
    aes_done       = 1'b0;
    aes_ciphertext = 128'd0;
  endtask

  task automatic do_start();
    logic [255:0] ops;
    bus_store(32'd77, 32'h1);
    n_total++;
    if (aes_start !== 1'b1) $display("FAIL start_pulse got %b exp 1", aes_start);
    else n_pass++;
    n_total++;
    if (op_q.size() == 0) begin
      $display("FAIL start_operands got empty queue exp queued operands");
    end else begin
      ops = op_q.pop_front();
      if ({aes_key, aes_plaintext} !== ops)
        $display("FAIL start_operands got %h exp %h", {aes_key, aes_plaintext}, ops);
      else n_pass++;
    end
    tick();
    n_total++;
    if (aes_start !== 1'b0) $display("FAIL start_width got %b exp 0", aes_start);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (3) tick();
    n_total++;
    if (aes_read !== 32'd0) $display("FAIL rst_read got %h exp 0", aes_read); else n_pass++;
    n_total++;
    if (aes_start !== 1'b0) $display("FAIL rst_start got %b exp 0", aes_start); else n_pass++;
    n_total++;
    if (aes_key !== 128'd0) $display("FAIL rst_key got %h exp 0", aes_key); else n_pass++;
    n_total++;
    if (aes_plaintext !== 128'd0) $display("FAIL rst_pt got %h exp 0", aes_plaintext); else n_pass++;
    reset = 1'b1;
    tick();
    read_view(3'd0, v);
    n_total++;
    if (v !== 32'd0) $display("FAIL rst_status got %h exp 0", v); else n_pass++;
  endtask

  task automatic test_encrypt();
    logic [255:0] ops;
    logic [127:0] ct;
    logic [127:0] exp_ct;
    logic [31:0]  v;
    load8(32'h00010203, ops);
    do_start();
    n_total++;
    if (aes_key[127:96] !== 32'h00010203)
      $display("FAIL enc_key_word0 got %h exp %h", aes_key[127:96], 32'h00010203);
    else n_pass++;
    read_view(3'd0, v);
    n_total++;
    if (v !== 32'h081) $display("FAIL enc_busy_status got %h exp %h", v, 32'h081); else n_pass++;
    repeat (6) tick();
    ct = {4{32'hAAAAAAAA}};
    ct_q.push_back(ct);
    model_result = ct;
    pulse_done(ct);
    read_view(3'd0, v);
    n_total++;
    if (v !== 32'h082) $display("FAIL enc_done_status got %h exp %h", v, 32'h082); else n_pass++;
    exp_ct = ct_q.pop_front();
    for (int i = 1; i <= 4; i++) begin
      read_view(3'(i), v);
      n_total++;
      if (v !== exp_ct[127 - 32*(i-1) -: 32])
        $display("FAIL enc_result_w%0d got %h exp %h", i - 1, v, exp_ct[127 - 32*(i-1) -: 32]);
      else n_pass++;
    end
    read_view(3'd5, v);
    n_total++;
    if (v !== 32'd8) $display("FAIL enc_wptr_view got %h exp 8", v); else n_pass++;
  endtask

  task automatic test_load_err();
    logic [31:0] v;
    bus_store(32'd77, 32'h2);
    read_view(3'd0, v);
    n_total++;
    if (v !== 32'h000) $display("FAIL le_clear_status got %h exp 0", v); else n_pass++;
    for (int i = 0; i < 5; i++) bus_store(32'd56 + 32'(i % 4), 32'h11110000 + 32'(i));
    bus_store(32'd77, 32'h1);
    n_total++;
    if (aes_start !== 1'b0) $display("FAIL le_no_start got %b exp 0", aes_start); else n_pass++;
    read_view(3'd0, v);
    n_total++;
    if (v !== 32'h054) $display("FAIL le_short_status got %h exp %h", v, 32'h054); else n_pass++;
    for (int i = 5; i < 8; i++) bus_store(32'd56 + 32'(i % 4), 32'h11110000 + 32'(i));
    read_view(3'd5, v);
    n_total++;
    if (v !== 32'd8) $display("FAIL le_still_load got %h exp 8", v); else n_pass++;
    bus_store(32'd58, 32'hDEADBEEF);
    n_total++;
    if (aes_plaintext[31:0] !== 32'h11110007)
      $display("FAIL le_word7_kept got %h exp %h", aes_plaintext[31:0], 32'h11110007);
    else n_pass++;
    read_view(3'd0, v);
    n_total++;
    if (v !== 32'h084) $display("FAIL le_full_status got %h exp %h", v, 32'h084); else n_pass++;
  endtask

  task automatic test_busy_store_and_clear();
    logic [255:0] ops;
    logic [31:0]  v;
    bus_store(32'd77, 32'h2);
    load8(32'h20212223, ops);
    do_start();
    bus_store(32'd56, 32'h12345678);
    n_total++;
    if (aes_plaintext !== ops[127:0])
      $display("FAIL bs_pt_stable got %h exp %h", aes_plaintext, ops[127:0]);
    else n_pass++;
    read_view(3'd0, v);
    n_total++;
    if (v !== 32'h085) $display("FAIL bs_err_status got %h exp %h", v, 32'h085); else n_pass++;
    // CLEAR coincident with completion: CLEAR wins, result kept.
    MemWriteX      = 1'b1;
    ALUResultX     = 32'd77;
    RD2X           = 32'h2;
    aes_done       = 1'b1;
    aes_ciphertext = {4{32'h55555555}};
    tick();
    MemWriteX      = 1'b0;
    ALUResultX     = 32'd0;
    RD2X           = 32'd0;
    aes_done       = 1'b0;
    aes_ciphertext = 128'd0;
    read_view(3'd0, v);
    n_total++;
    if (v !== 32'h000) $display("FAIL clr_status got %h exp 0", v); else n_pass++;
    read_view(3'd1, v);
    n_total++;
    if (v !== model_result[127:96])
      $display("FAIL clr_result_kept got %h exp %h", v, model_result[127:96]);
    else n_pass++;
    pulse_done({4{32'h33333333}});
    read_view(3'd2, v);
    n_total++;
    if (v !== model_result[95:64])
      $display("FAIL idle_done_ignored got %h exp %h", v, model_result[95:64]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    logic [255:0] ops;
    logic [31:0]  v;
    bus_store(32'd77, 32'h2);
    load8(32'h30313233, ops);
    do_start();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_total++;
    if (aes_read !== 32'd0) $display("FAIL rmb_read got %h exp 0", aes_read); else n_pass++;
    n_total++;
    if (aes_key !== 128'd0) $display("FAIL rmb_key got %h exp 0", aes_key); else n_pass++;
    n_total++;
    if (aes_plaintext !== 128'd0) $display("FAIL rmb_pt got %h exp 0", aes_plaintext); else n_pass++;
    reset = 1'b1;
    model_result = 128'd0;
    tick();
    pulse_done({4{32'h77777777}});
    n_total++;
    if (aes_start !== 1'b0) $display("FAIL rmb_start got %b exp 0", aes_start); else n_pass++;
    read_view(3'd0, v);
    n_total++;
    if (v !== 32'h000) $display("FAIL rmb_status got %h exp 0", v); else n_pass++;
    read_view(3'd1, v);
    n_total++;
    if (v !== 32'd0) $display("FAIL rmb_result got %h exp 0", v); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [255:0] ops;
    logic [31:0]  v;
    bus_store(32'd77, 32'h2);
    load8(32'h40414243, ops);
    do_start();
`ifdef AES_MMIO_TIMEOUT_EN
    begin
      int busy_cnt;
      busy_cnt = 0;
      for (int k = 0; k < 200; k++) begin
        if (aes_read[0] !== 1'b1) break;
        busy_cnt++;
        tick();
      end
      n_total++;
      if (busy_cnt != 16) $display("FAIL tmo_busy_cycles got %0d exp 16", busy_cnt); else n_pass++;
      n_total++;
      if (aes_read !== 32'h08C) $display("FAIL tmo_status got %h exp %h", aes_read, 32'h08C); else n_pass++;
      read_view(3'd1, v);
      n_total++;
      if (v !== model_result[127:96])
        $display("FAIL tmo_result_kept got %h exp %h", v, model_result[127:96]);
      else n_pass++;
    end
`else
    repeat (120) tick();
    n_total++;
    if (aes_read !== 32'h081) $display("FAIL busy_persist got %h exp %h", aes_read, 32'h081); else n_pass++;
    pulse_done({4{32'h99999999}});
    tick();
    n_total++;
    if (aes_read !== 32'h082) $display("FAIL late_done_status got %h exp %h", aes_read, 32'h082); else n_pass++;
    v = 32'd0;
`endif
    bus_store(32'd77, 32'h2);
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_load_err();
    test_busy_store_and_clear();
    test_reset_mid_busy();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
